// File: rtl/hp_capture_if.sv
// Framebuffer BRAM write port driven by the HP capture stage.
interface hp_capture_if #(
  parameter int ADDR_W = 18
);
  logic [ADDR_W-1:0] BRAM_ADDR;
  logic [7:0]        BRAM_DIN;
  logic              BRAM_WE;

  modport master (output BRAM_ADDR, BRAM_DIN, BRAM_WE);
  modport slave  (input  BRAM_ADDR, BRAM_DIN, BRAM_WE);
endinterface

// File: rtl/hp_capture.sv
// HP raw display capture: synchronises the HP pixel interface into CLK and
// writes the active window to the framebuffer at Y*H_ACTIVE + X.
module hp_capture #(
  parameter int H_ACTIVE = 576,
  parameter int V_ACTIVE = 378,
  parameter int H_OFFSET = 8,
  parameter int V_OFFSET = 2,
  parameter int ADDR_W   = 18,
  parameter int SYNC_POL = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       HP_PCLK,
  input  logic       HP_HSYNC,
  input  logic       HP_VSYNC,
  input  logic [1:0] HP_VIDEO,
  hp_capture_if.master bram,
  output logic       FRAME_DONE,
  output logic       SYNC_ERR
);

  localparam int X_W      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int SKIP_MAX = (H_OFFSET > V_OFFSET) ? H_OFFSET : V_OFFSET;
  localparam int S_W      = $clog2(SKIP_MAX + 1);

  typedef enum logic [2:0] {
    WAIT_VS,
    V_SKIP,
    WAIT_HS,
    H_SKIP,
    CAPTURE,
    LINE_END
  } state_t;

  state_t            state;
  logic [S_W-1:0]    skip_cnt;
  logic [X_W-1:0]    x_cnt;
  logic [Y_W-1:0]    y_cnt;
  logic [ADDR_W-1:0] line_base;

  logic       hs_in;
  logic       vs_in;
  logic [4:0] raw;
  logic [4:0] sync1;
  logic [4:0] sync2;
  logic [4:0] stage3;
  logic [2:0] prev;
  logic [2:0] rise;
  logic       pclk_rise;
  logic       hs_rise;
  logic       vs_rise;
  logic [1:0] video;
  logic       end_line;

  // Syncs are normalised to active-high before synchronisation.
  always_comb begin
    hs_in = (SYNC_POL != 0) ? HP_HSYNC : ~HP_HSYNC;
    vs_in = (SYNC_POL != 0) ? HP_VSYNC : ~HP_VSYNC;
    raw   = {HP_PCLK, hs_in, vs_in, HP_VIDEO};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1  <= '0;
      sync2  <= '0;
      stage3 <= '0;
      prev   <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      stage3 <= sync2;
      prev   <= stage3[4:2];
    end
  end

  // Video comes from the same stage as the PCLK edge so the pair stays aligned.
  always_comb begin
    rise      = stage3[4:2] & ~prev;
    pclk_rise = rise[2];
    hs_rise   = rise[1];
    vs_rise   = rise[0];
    video     = stage3[1:0];
    end_line  = (state == LINE_END) ||
                (hs_rise && (state == CAPTURE || state == H_SKIP));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= WAIT_VS;
      skip_cnt       <= '0;
      x_cnt          <= '0;
      y_cnt          <= '0;
      line_base      <= '0;
      bram.BRAM_ADDR <= '0;
      bram.BRAM_DIN  <= '0;
      bram.BRAM_WE   <= 1'b0;
      FRAME_DONE     <= 1'b0;
      SYNC_ERR       <= 1'b0;
    end else begin
      bram.BRAM_WE <= 1'b0;
      FRAME_DONE   <= 1'b0;
      if (vs_rise && state != WAIT_VS) begin
        SYNC_ERR <= 1'b1;
        skip_cnt <= '0;
        state    <= ENABLE ? V_SKIP : WAIT_VS;
      end else if (end_line) begin
        // A truncating HSYNC also opens the next line, so go straight to H_SKIP.
        if (y_cnt == Y_W'(V_ACTIVE - 1)) begin
          FRAME_DONE <= 1'b1;
          SYNC_ERR   <= 1'b0;
          state      <= WAIT_VS;
        end else begin
          y_cnt     <= y_cnt + 1'b1;
          line_base <= line_base + ADDR_W'(H_ACTIVE);
          skip_cnt  <= '0;
          state     <= hs_rise ? H_SKIP : WAIT_HS;
        end
      end else begin
        case (state)
          WAIT_VS: begin
            if (vs_rise && ENABLE) begin
              skip_cnt <= '0;
              state    <= V_SKIP;
            end
          end
          V_SKIP: begin
            if (hs_rise) begin
              if (skip_cnt == S_W'(V_OFFSET - 1)) begin
                y_cnt     <= '0;
                line_base <= '0;
                state     <= WAIT_HS;
              end else begin
                skip_cnt <= skip_cnt + 1'b1;
              end
            end
          end
          WAIT_HS: begin
            if (hs_rise) begin
              skip_cnt <= '0;
              state    <= H_SKIP;
            end
          end
          H_SKIP: begin
            if (pclk_rise) begin
              if (skip_cnt == S_W'(H_OFFSET - 1)) begin
                x_cnt <= '0;
                state <= CAPTURE;
              end else begin
                skip_cnt <= skip_cnt + 1'b1;
              end
            end
          end
          CAPTURE: begin
            if (pclk_rise) begin
              bram.BRAM_ADDR <= line_base + ADDR_W'(x_cnt);
              bram.BRAM_DIN  <= {4{video}};
              bram.BRAM_WE   <= 1'b1;
              if (x_cnt == X_W'(H_ACTIVE - 1)) begin
                state <= LINE_END;
              end else begin
                x_cnt <= x_cnt + 1'b1;
              end
            end
          end
          default: state <= WAIT_VS;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hp_capture.sv
// Scoreboard bench for hp_capture on a reduced 16x8 window.
module tb_hp_capture;

  localparam int H_ACTIVE = 16;
  localparam int V_ACTIVE = 8;
  localparam int H_OFFSET = 3;
  localparam int V_OFFSET = 2;
  localparam int ADDR_W   = 8;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       ENABLE = 1'b0;
  logic       HP_PCLK = 1'b0;
  logic       HP_HSYNC = 1'b0;
  logic       HP_VSYNC = 1'b0;
  logic [1:0] HP_VIDEO = 2'd0;
  logic       FRAME_DONE;
  logic       SYNC_ERR;

  hp_capture_if #(.ADDR_W(ADDR_W)) bus ();

  hp_capture #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .H_OFFSET(H_OFFSET),
    .V_OFFSET(V_OFFSET),
    .ADDR_W  (ADDR_W),
    .SYNC_POL(1)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ENABLE    (ENABLE),
    .HP_PCLK   (HP_PCLK),
    .HP_HSYNC  (HP_HSYNC),
    .HP_VSYNC  (HP_VSYNC),
    .HP_VIDEO  (HP_VIDEO),
    .bram      (bus),
    .FRAME_DONE(FRAME_DONE),
    .SYNC_ERR  (SYNC_ERR)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  int push_cnt = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic push(input int addr, input logic [1:0] v);
    exp_q.push_back({addr[7:0], {4{v}}});
    push_cnt++;
  endtask

  // Every write strobe is matched against the oldest expected pixel.
  always @(negedge CLK) begin
    logic [15:0] e;
    if (FRAME_DONE) done_cnt++;
    if (bus.BRAM_WE) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_we", {24'd0, bus.BRAM_ADDR}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {24'd0, bus.BRAM_ADDR}, {24'd0, e[15:8]});
        chk("wr_din", {24'd0, bus.BRAM_DIN}, {24'd0, e[7:0]});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_vs();
    HP_PCLK = 1'b0;
    HP_VSYNC = 1'b1;
    cyc(3);
    HP_VSYNC = 1'b0;
    cyc(3);
  endtask

  // coinc puts a PCLK rising edge in the same sample as the HSYNC edge.
  task automatic pulse_hs(input bit coinc);
    HP_PCLK = 1'b0;
    if (coinc) begin
      HP_VIDEO = 2'd3;
      cyc(2);
      HP_PCLK = 1'b1;
    end
    HP_HSYNC = 1'b1;
    cyc(3);
    HP_HSYNC = 1'b0;
    HP_PCLK = 1'b0;
    cyc(3);
  endtask

  task automatic pix(input logic [1:0] v);
    HP_VIDEO = v;
    HP_PCLK = 1'b0;
    cyc(2);
    HP_PCLK = 1'b1;
    cyc(2);
  endtask

  task automatic line(input int npix, input bit capt, input int y, input bit coinc);
    pulse_hs(coinc);
    for (int i = 0; i < H_OFFSET + npix; i++) begin
      int x;
      logic [1:0] v;
      x = i - H_OFFSET;
      v = i[1:0] ^ x[1:0] ^ x[1:0];
      if (x >= 0) v = x[1:0];
      if (capt && x >= 0 && x < H_ACTIVE) push(y * H_ACTIVE + x, v);
      pix(v);
    end
  endtask

  task automatic frame(input bit en, input int n_lines, input int short_y, input int short_len,
                       input int drop_y, input int exp_err_vs);
    int done0;
    int wr0;
    int push0;
    bit complete;
    done0 = done_cnt;
    wr0 = wr_cnt;
    push0 = push_cnt;
    complete = en && (n_lines >= V_ACTIVE);
    ENABLE = en;
    pulse_vs();
    if (exp_err_vs >= 0) chk("sync_err_at_vs", {31'd0, SYNC_ERR}, exp_err_vs);
    for (int b = 0; b < V_OFFSET; b++) line(H_ACTIVE + 2, 1'b0, 0, 1'b0);
    for (int y = 0; y < n_lines; y++) begin
      line((y == short_y) ? short_len : H_ACTIVE + 2, en && (y < V_ACTIVE), y,
           (short_y >= 0) && (y == short_y + 1));
      if (y == drop_y) ENABLE = 1'b0;
    end
    cyc(10);
    chk("queue_drained", exp_q.size(), 0);
    chk("frame_done_cnt", done_cnt - done0, complete ? 1 : 0);
    chk("write_cnt", wr_cnt - wr0, push_cnt - push0);
    if (complete) chk("sync_err_cleared", {31'd0, SYNC_ERR}, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, {31'd0, bus.BRAM_WE}, 0);
    chk({tag, "_addr"}, {24'd0, bus.BRAM_ADDR}, 0);
    chk({tag, "_din"}, {24'd0, bus.BRAM_DIN}, 0);
    chk({tag, "_done"}, {31'd0, FRAME_DONE}, 0);
    chk({tag, "_err"}, {31'd0, SYNC_ERR}, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    cyc(3);
    chk_reset_outputs("reset");
    RESET = 1'b0;
    cyc(4);

    // Nominal frame with two extra lines beyond the window.
    wr0 = wr_cnt;
    frame(1'b1, V_ACTIVE + 2, -1, 0, -1, 0);
    chk("nominal_writes", wr_cnt - wr0, H_ACTIVE * V_ACTIVE);

    // Short line 5 (9 pixels), next HSYNC coincides with a PCLK edge.
    frame(1'b1, V_ACTIVE, 5, 9, -1, 0);

    // Premature VSYNC after 4 lines, then a full frame.
    frame(1'b1, 4, -1, 0, -1, 0);
    frame(1'b1, V_ACTIVE, -1, 0, -1, 1);

    // Disabled frame, then ENABLE dropped mid-frame and the next frame skipped.
    frame(1'b0, V_ACTIVE, -1, 0, -1, -1);
    frame(1'b1, V_ACTIVE, -1, 0, 3, 0);
    frame(1'b0, V_ACTIVE, -1, 0, -1, -1);

    // Latency of a single pixel, then reset mid-line.
    ENABLE = 1'b1;
    pulse_vs();
    for (int b = 0; b < V_OFFSET; b++) line(H_ACTIVE + 2, 1'b0, 0, 1'b0);
    pulse_hs(1'b0);
    for (int i = 0; i < H_OFFSET + 8; i++) begin
      logic [1:0] v;
      v = 2'(i + 1);
      if (i >= H_OFFSET) push(i - H_OFFSET, v);
      pix(v);
    end
    HP_VIDEO = 2'd2;
    HP_PCLK = 1'b0;
    cyc(2);
    HP_PCLK = 1'b1;
    push(8, 2'd2);
    for (int k = 1; k <= 5; k++) begin
      cyc(1);
      chk("latency_we", {31'd0, bus.BRAM_WE}, (k == 4) ? 1 : 0);
    end
    HP_PCLK = 1'b0;
    HP_VIDEO = 2'd3;
    cyc(2);
    HP_PCLK = 1'b1;
    cyc(1);
    RESET = 1'b1;
    cyc(1);
    chk_reset_outputs("midline_reset");
    cyc(2);
    RESET = 1'b0;
    HP_PCLK = 1'b0;
    cyc(4);
    wr0 = wr_cnt;
    line(H_ACTIVE + 2, 1'b0, 0, 1'b0);
    line(H_ACTIVE + 2, 1'b0, 0, 1'b0);
    cyc(8);
    chk("no_write_after_reset", wr_cnt - wr0, 0);
    frame(1'b1, V_ACTIVE, -1, 0, -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/hp_capture.md
Name: hp_capture

Overview:
- Capture stage directly upstream of the framebuffer BRAM read by the VGA TX path.
- Samples the HP instrument's raw display interface (pixel clock, HSYNC, VSYNC, 2-bit video) in the system CLK domain.
- Windows the active H_ACTIVE x V_ACTIVE region and writes one byte per pixel to BRAM at address Y*H_ACTIVE + X, the same linear layout the TX path reads.

Parameters:
H_ACTIVE, 576, captured pixels per line
V_ACTIVE, 378, captured lines per frame
H_OFFSET, 8, pixel-clock edges skipped after HSYNC before pixel X=0
V_OFFSET, 2, HSYNC pulses skipped after VSYNC before line Y=0
ADDR_W, 18, BRAM address width (must hold H_ACTIVE*V_ACTIVE-1)
SYNC_POL, 1, active level of HP_HSYNC/HP_VSYNC (1 = active-high)

Ports:
CLK  in  1  system clock; must be at least 4x the HP pixel clock
RESET  in  1  synchronous, active-high reset
ENABLE  in  1  capture enable; sampled only at frame start
HP_PCLK  in  1  asynchronous HP pixel clock; data is valid on its rising edge
HP_HSYNC  in  1  asynchronous HP horizontal sync
HP_VSYNC  in  1  asynchronous HP vertical sync
HP_VIDEO  in  2  asynchronous HP intensity (0 off, 3 full)
BRAM_ADDR  out  ADDR_W  write address
BRAM_DIN  out  8  write data = {4{video}}: 0x00, 0x55, 0xAA, 0xFF
BRAM_WE  out  1  write strobe, one CLK per pixel
FRAME_DONE  out  1  one-CLK pulse after pixel (H_ACTIVE-1, V_ACTIVE-1) is written
SYNC_ERR  out  1  sticky flag for a short frame; cleared by RESET or by the next complete frame

Behaviour:
- Input synchronisation:
  - All five HP inputs pass through 2-FF synchronisers, then one further register stage.
  - Rising edges of HSYNC, VSYNC and PCLK are detected at the active level given by SYNC_POL.
  - Video is taken from the same register stage as the PCLK edge detect, so the two stay aligned.
- Latency: BRAM_WE is asserted 4 CLK after the HP_PCLK rising edge at the pin. BRAM_ADDR and BRAM_DIN are valid in the same cycle as BRAM_WE.
- Reset values: BRAM_ADDR=0, BRAM_DIN=0, BRAM_WE=0, FRAME_DONE=0, SYNC_ERR=0, state=WAIT_VS, all counters 0.
- Reset mid-frame: BRAM_WE is low from the cycle after RESET is sampled high. No partial write follows.
- State machine:
  - WAIT_VS: on a VSYNC edge with ENABLE=1, go to V_SKIP with the line counter at 0. With ENABLE=0, stay in WAIT_VS.
  - V_SKIP: count HSYNC edges. After V_OFFSET edges, go to WAIT_HS with Y=0 and line_base=0.
  - WAIT_HS: on an HSYNC edge, go to H_SKIP with the edge counter at 0.
  - H_SKIP: count PCLK edges. After H_OFFSET edges, go to CAPTURE with X=0.
  - CAPTURE: on each PCLK edge, write video to line_base+X and increment X.
    - After the write at X=H_ACTIVE-1, go to LINE_END.
    - Extra PCLK edges before the next HSYNC are ignored.
  - LINE_END:
    - If Y=V_ACTIVE-1: pulse FRAME_DONE, clear SYNC_ERR, go to WAIT_VS.
    - Otherwise: Y+=1, line_base+=H_ACTIVE, go to WAIT_HS.
- Address arithmetic is incremental: line_base is an accumulator and BRAM_ADDR = line_base + X. No multiplier is used. Addresses never exceed H_ACTIVE*V_ACTIVE-1.
- Boundary conditions:
  - Early HSYNC in CAPTURE (X<H_ACTIVE): the line is truncated, the remaining pixels of that line keep their old contents, and the block proceeds as in LINE_END, then H_SKIP for the new line.
  - VSYNC in any state other than WAIT_VS: the frame is abandoned, SYNC_ERR is set, there is no FRAME_DONE, and the block restarts at V_SKIP if ENABLE=1, otherwise WAIT_VS.
  - Lines beyond V_ACTIVE are ignored, because the block is in WAIT_VS.
  - ENABLE dropping mid-frame: the current frame completes. ENABLE=0 only blocks the next frame start.
  - HSYNC and PCLK edges in the same cycle: HSYNC takes priority and the PCLK edge is discarded.

Test Plan:
- Nominal frame (SYNC_POL=1, offsets 8/2, 576x378, ramp video with pixel value = X mod 4) -> exactly 217728 writes, addresses 0..217727 each written once, BRAM_DIN at addr 577 = 0x55, one FRAME_DONE, SYNC_ERR=0.
- Latency check: single PCLK rising edge at the pin in CAPTURE -> BRAM_WE high exactly 4 CLK later for 1 CLK.
- Short line: HSYNC after 300 pixels on line 5 -> last line-5 write at addr 5*576+299, next write at addr 6*576+0, frame still completes with FRAME_DONE.
- Premature VSYNC after line 100 -> SYNC_ERR=1, no FRAME_DONE; next full frame starts again at addr 0, then FRAME_DONE and SYNC_ERR cleared.
- RESET asserted mid-line at X=200 -> BRAM_WE=0 next cycle, all outputs at reset values, no writes until a new VSYNC.
- ENABLE=0 at VSYNC -> zero writes that frame. ENABLE taken low mid-frame -> frame completes, next frame is skipped.
